// File: rtl/vga_pkg.sv
// Shared VGA timing constants and types.
// Used by the scanout reader and by the fractal renderer.
package vga_pkg;

  localparam int H_ACTIVE = 640;
  localparam int H_FP     = 16;
  localparam int H_SYNC   = 96;
  localparam int H_BP     = 48;
  localparam int H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;

  localparam int V_ACTIVE = 480;
  localparam int V_FP     = 10;
  localparam int V_SYNC   = 2;
  localparam int V_BP     = 33;
  localparam int V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam int H_SYNC_START = H_ACTIVE + H_FP;
  localparam int H_SYNC_END   = H_SYNC_START + H_SYNC;
  localparam int V_SYNC_START = V_ACTIVE + V_FP;
  localparam int V_SYNC_END   = V_SYNC_START + V_SYNC;

  localparam int FB_WIDTH = H_ACTIVE;
  localparam int CNT_W    = 10;

  typedef struct packed {
    logic hs;
    logic vs;
    logic blank;
    logic fs;
  } vga_ctl_t;

  localparam vga_ctl_t CTL_IDLE = '{
    hs: 1'b1, vs: 1'b1, blank: 1'b0, fs: 1'b0
  };

  function automatic logic [23:0] rgb332_expand(
    input logic [7:0] d
  );
    return {d[7:5], d[7:5], d[7:6],
            d[4:2], d[4:2], d[4:3],
            d[1:0], d[1:0], d[1:0], d[1:0]};
  endfunction

endpackage

// File: rtl/vga_timing_gen.sv
// Pixel/line counters and raw sync, blank and frame-start decode.
// Everything here is aligned with the counter value, not the pins.
module vga_timing_gen #(
  parameter int H_ACTIVE = vga_pkg::H_ACTIVE,
  parameter int H_FP     = vga_pkg::H_FP,
  parameter int H_SYNC   = vga_pkg::H_SYNC,
  parameter int H_BP     = vga_pkg::H_BP,
  parameter int V_ACTIVE = vga_pkg::V_ACTIVE,
  parameter int V_FP     = vga_pkg::V_FP,
  parameter int V_SYNC   = vga_pkg::V_SYNC,
  parameter int V_BP     = vga_pkg::V_BP
) (
  input  logic                      clock,
  input  logic                      reset,
  output logic [vga_pkg::CNT_W-1:0] h_count,
  output logic [vga_pkg::CNT_W-1:0] v_count,
  output logic                      active,
  output vga_pkg::vga_ctl_t         ctl
);
  import vga_pkg::*;

  localparam int HT  = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int VT  = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HS0 = H_ACTIVE + H_FP;
  localparam int HS1 = HS0 + H_SYNC;
  localparam int VS0 = V_ACTIVE + V_FP;
  localparam int VS1 = VS0 + V_SYNC;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      h_count <= '0;
      v_count <= '0;
    end else if (h_count == CNT_W'(HT - 1)) begin
      h_count <= '0;
      if (v_count == CNT_W'(VT - 1))
        v_count <= '0;
      else
        v_count <= v_count + 1'b1;
    end else begin
      h_count <= h_count + 1'b1;
    end
  end

  always_comb begin
    active = (h_count < CNT_W'(H_ACTIVE)) &&
             (v_count < CNT_W'(V_ACTIVE));
    ctl.hs = !((h_count >= CNT_W'(HS0)) &&
               (h_count <  CNT_W'(HS1)));
    ctl.vs = !((v_count >= CNT_W'(VS0)) &&
               (v_count <  CNT_W'(VS1)));
    ctl.blank = active;
    ctl.fs = (h_count == '0) && (v_count == '0);
  end

endmodule

// File: rtl/vga_sram_scanout.sv
// VGA scanout: fetches RGB332 pixels from SRAM one per clock and
// drives colour, syncs and blank aligned to the same pixel.
module vga_sram_scanout #(
  parameter logic [31:0] vga_in_base_address = 32'h0000_0000,
  parameter int READ_LATENCY = 2,
  parameter int H_ACTIVE = vga_pkg::H_ACTIVE,
  parameter int H_FP     = vga_pkg::H_FP,
  parameter int H_SYNC   = vga_pkg::H_SYNC,
  parameter int H_BP     = vga_pkg::H_BP,
  parameter int V_ACTIVE = vga_pkg::V_ACTIVE,
  parameter int V_FP     = vga_pkg::V_FP,
  parameter int V_SYNC   = vga_pkg::V_SYNC,
  parameter int V_BP     = vga_pkg::V_BP
) (
  input  logic        clock,
  input  logic        reset,
  output logic [31:0] sram_address,
  output logic        sram_read,
  input  logic [7:0]  sram_readdata,
  output logic [7:0]  vga_r,
  output logic [7:0]  vga_g,
  output logic [7:0]  vga_b,
  output logic        vga_hs,
  output logic        vga_vs,
  output logic        vga_blank_n,
  output logic        frame_start
);
  import vga_pkg::*;

  localparam int DEPTH = READ_LATENCY + 2;

  logic [CNT_W-1:0] h_count;
  logic [CNT_W-1:0] v_count;
  logic             active;
  vga_ctl_t         ctl_raw;
  vga_ctl_t         ctl_pipe [DEPTH];
  logic [31:0]      pix_addr;

  vga_timing_gen #(
    .H_ACTIVE (H_ACTIVE),
    .H_FP     (H_FP),
    .H_SYNC   (H_SYNC),
    .H_BP     (H_BP),
    .V_ACTIVE (V_ACTIVE),
    .V_FP     (V_FP),
    .V_SYNC   (V_SYNC),
    .V_BP     (V_BP)
  ) u_timing (
    .clock   (clock),
    .reset   (reset),
    .h_count (h_count),
    .v_count (v_count),
    .active  (active),
    .ctl     (ctl_raw)
  );

  assign pix_addr = vga_in_base_address + 32'(h_count) +
                    32'(v_count) * 32'(H_ACTIVE);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sram_read    <= 1'b0;
      sram_address <= vga_in_base_address;
    end else begin
      sram_read <= active;
      if (active)
        sram_address <= pix_addr;
    end
  end

  // Stage READ_LATENCY lines up with the returning read data.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++)
        ctl_pipe[i] <= CTL_IDLE;
    end else begin
      ctl_pipe[0] <= ctl_raw;
      for (int i = 1; i < DEPTH; i++)
        ctl_pipe[i] <= ctl_pipe[i-1];
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      {vga_r, vga_g, vga_b} <= '0;
    end else if (ctl_pipe[READ_LATENCY].blank) begin
      {vga_r, vga_g, vga_b} <= rgb332_expand(sram_readdata);
    end else begin
      {vga_r, vga_g, vga_b} <= '0;
    end
  end

  assign vga_hs      = ctl_pipe[DEPTH-1].hs;
  assign vga_vs      = ctl_pipe[DEPTH-1].vs;
  assign vga_blank_n = ctl_pipe[DEPTH-1].blank;
  assign frame_start = ctl_pipe[DEPTH-1].fs;

endmodule

// File: tb/tb_vga_sram_scanout.sv
// Bench for vga_sram_scanout: one full-size instance and two
// shrunk-timing instances at read latency 1 and 4.
module tb_vga_sram_scanout;

  typedef struct packed {
    int ha; int hf; int hsw; int hb;
    int va; int vf; int vsw; int vb;
    int lat;
    logic [31:0] base;
    int mode;
  } cfg_t;

  typedef struct packed {
    logic [23:0] rgb;
    logic hs;
    logic vs;
    logic blank;
    logic fs;
  } out_t;

  localparam out_t IDLE = '{
    rgb: 24'h0, hs: 1'b1, vs: 1'b1, blank: 1'b0, fs: 1'b0
  };

  logic clock;
  logic reset;
  int   n;
  int   tests;
  int   fails;

  logic        s_rd   [3];
  logic [31:0] s_addr [3];
  logic [7:0]  s_data [3];
  logic [7:0]  s_r    [3];
  logic [7:0]  s_g    [3];
  logic [7:0]  s_b    [3];
  logic        s_hs   [3];
  logic        s_vs   [3];
  logic        s_bl   [3];
  logic        s_fs   [3];

  logic [7:0]  rnd     [256];
  logic        hist_rd [3][8];
  logic [31:0] hist_a  [3][8];

  vga_sram_scanout #(
    .vga_in_base_address (32'h0000_1000),
    .READ_LATENCY        (2)
  ) u_main (
    .clock (clock), .reset (reset),
    .sram_address (s_addr[0]), .sram_read (s_rd[0]),
    .sram_readdata (s_data[0]),
    .vga_r (s_r[0]), .vga_g (s_g[0]), .vga_b (s_b[0]),
    .vga_hs (s_hs[0]), .vga_vs (s_vs[0]),
    .vga_blank_n (s_bl[0]), .frame_start (s_fs[0])
  );

  vga_sram_scanout #(
    .vga_in_base_address (32'h0), .READ_LATENCY (1),
    .H_ACTIVE (40), .H_FP (4), .H_SYNC (6), .H_BP (6),
    .V_ACTIVE (6), .V_FP (1), .V_SYNC (2), .V_BP (2)
  ) u_l1 (
    .clock (clock), .reset (reset),
    .sram_address (s_addr[1]), .sram_read (s_rd[1]),
    .sram_readdata (s_data[1]),
    .vga_r (s_r[1]), .vga_g (s_g[1]), .vga_b (s_b[1]),
    .vga_hs (s_hs[1]), .vga_vs (s_vs[1]),
    .vga_blank_n (s_bl[1]), .frame_start (s_fs[1])
  );

  vga_sram_scanout #(
    .vga_in_base_address (32'h0), .READ_LATENCY (4),
    .H_ACTIVE (40), .H_FP (4), .H_SYNC (6), .H_BP (6),
    .V_ACTIVE (6), .V_FP (1), .V_SYNC (2), .V_BP (2)
  ) u_l4 (
    .clock (clock), .reset (reset),
    .sram_address (s_addr[2]), .sram_read (s_rd[2]),
    .sram_readdata (s_data[2]),
    .vga_r (s_r[2]), .vga_g (s_g[2]), .vga_b (s_b[2]),
    .vga_hs (s_hs[2]), .vga_vs (s_vs[2]),
    .vga_blank_n (s_bl[2]), .frame_start (s_fs[2])
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  // Edges since reset release.
  always @(posedge clock or posedge reset) begin
    if (reset) n <= 0;
    else       n <= n + 1;
  end

  function automatic cfg_t get_cfg(input int i);
    cfg_t c;
    c = '{ha: 640, hf: 16, hsw: 96, hb: 48,
          va: 480, vf: 10, vsw: 2, vb: 33,
          lat: 2, base: 32'h1000, mode: 0};
    if (i != 0)
      c = '{ha: 40, hf: 4, hsw: 6, hb: 6,
            va: 6, vf: 1, vsw: 2, vb: 2,
            lat: (i == 1) ? 1 : 4, base: 32'h0, mode: 1};
    return c;
  endfunction

  function automatic int ht(input cfg_t c);
    return c.ha + c.hf + c.hsw + c.hb;
  endfunction

  function automatic int vt(input cfg_t c);
    return c.va + c.vf + c.vsw + c.vb;
  endfunction

  function automatic logic [31:0] paddr(
    input cfg_t c, input int h, input int v
  );
    return c.base + 32'(h) + 32'(v) * 32'(c.ha);
  endfunction

  function automatic logic [7:0] data_of(
    input cfg_t c, input logic [31:0] a
  );
    int x;
    if (c.mode == 1) return a[7:0];
    x = int'((a - c.base) % 32'(c.ha));
    case (x)
      0: return 8'hFF;
      1: return 8'h1C;
      2: return 8'h03;
      3: return 8'hE0;
      4: return 8'h00;
      default: return rnd[a[7:0]] ^ a[15:8];
    endcase
  endfunction

  function automatic logic [23:0] expand(input logic [7:0] d);
    logic [7:0] r, g, b;
    r = {d[7:5], d[7:5], d[7:6]};
    g = {d[4:2], d[4:2], d[4:3]};
    b = {4{d[1:0]}};
    return {r, g, b};
  endfunction

  function automatic logic [23:0] pat_rgb(input int x);
    case (x)
      0: return 24'hFFFFFF;
      1: return 24'h00FF00;
      2: return 24'h0000FF;
      3: return 24'hFF0000;
      default: return 24'h000000;
    endcase
  endfunction

  function automatic logic exp_rd(input cfg_t c, input int nn);
    int k;
    if (nn < 1) return 1'b0;
    k = nn - 1;
    return (k % ht(c) < c.ha) && ((k / ht(c)) % vt(c) < c.va);
  endfunction

  // Address holds at the last pixel strobed before the current position.
  function automatic logic [31:0] exp_addr(input cfg_t c, input int nn);
    int k, h, v;
    if (nn < 1) return c.base;
    k = nn - 1;
    h = k % ht(c);
    v = (k / ht(c)) % vt(c);
    if (v >= c.va) return paddr(c, c.ha - 1, c.va - 1);
    if (h >= c.ha) return paddr(c, c.ha - 1, v);
    return paddr(c, h, v);
  endfunction

  function automatic out_t exp_out(input cfg_t c, input int nn);
    int k, h, v;
    logic act;
    out_t o;
    k = nn - (c.lat + 2);
    if (k < 0) return IDLE;
    h = k % ht(c);
    v = (k / ht(c)) % vt(c);
    act = (h < c.ha) && (v < c.va);
    o.hs = !(h >= c.ha + c.hf && h < c.ha + c.hf + c.hsw);
    o.vs = !(v >= c.va + c.vf && v < c.va + c.vf + c.vsw);
    o.blank = act;
    o.fs = (h == 0) && (v == 0);
    o.rgb = act ? expand(data_of(c, paddr(c, h, v))) : 24'h0;
    return o;
  endfunction

  function automatic out_t act_out(input int i);
    return '{rgb: {s_r[i], s_g[i], s_b[i]}, hs: s_hs[i],
             vs: s_vs[i], blank: s_bl[i], fs: s_fs[i]};
  endfunction

  // SRAM model: answers each strobe lat cycles later, 0xFF otherwise.
  initial begin
    cfg_t c;
    for (int i = 0; i < 3; i++) begin
      s_data[i] = 8'hFF;
      for (int j = 0; j < 8; j++) begin
        hist_rd[i][j] = 1'b0;
        hist_a[i][j]  = 32'h0;
      end
    end
    forever begin
      @(negedge clock);
      for (int i = 0; i < 3; i++) begin
        c = get_cfg(i);
        for (int j = 7; j > 0; j--) begin
          hist_rd[i][j] = hist_rd[i][j-1];
          hist_a[i][j]  = hist_a[i][j-1];
        end
        hist_rd[i][0] = s_rd[i];
        hist_a[i][0]  = s_addr[i];
        s_data[i] = hist_rd[i][c.lat] ?
                    data_of(c, hist_a[i][c.lat]) : 8'hFF;
      end
    end
  end

  task automatic test_reset();
    cfg_t c;
    logic [23:0] want;
    reset = 1'b1;
    @(negedge clock);
    for (int i = 0; i < 3; i++) begin
      c = get_cfg(i);
      tests++;
      if (s_rd[i] !== 1'b0 || s_addr[i] !== c.base) begin
        fails++;
        $display("FAIL reset_fetch[%0d]: rd=%b addr=%h, want 0 %h",
                 i, s_rd[i], s_addr[i], c.base);
      end
      tests++;
      if (act_out(i) !== IDLE) begin
        fails++;
        $display("FAIL reset_out[%0d]: got %h want %h",
                 i, act_out(i), IDLE);
      end
    end
    #2 reset = 1'b0;
    for (int e = 1; e <= 5; e++) begin
      @(negedge clock);
      tests++;
      if (n !== e || s_rd[0] !== 1'b1 ||
          s_addr[0] !== 32'h1000 + 32'(e - 1)) begin
        fails++;
        $display("FAIL startup_fetch e=%0d: rd=%b addr=%h, want 1 %h",
                 e, s_rd[0], s_addr[0], 32'h1000 + 32'(e - 1));
      end
      want = (e < 4) ? 24'h0 : (e == 4) ? 24'hFFFFFF : 24'h00FF00;
      tests++;
      if (s_fs[0] !== (e == 4) || s_bl[0] !== (e >= 4) ||
          {s_r[0], s_g[0], s_b[0]} !== want) begin
        fails++;
        $display("FAIL startup_out e=%0d: fs=%b bl=%b rgb=%h, want %b %b %h",
                 e, s_fs[0], s_bl[0], {s_r[0], s_g[0], s_b[0]},
                 (e == 4), (e >= 4), want);
      end
    end
  endtask

  task automatic test_address();
    cfg_t c;
    int bad = 0;
    int cnt1 = 0;
    string msg = "";
    while (n < 1700) begin
      @(negedge clock);
      for (int i = 0; i < 3; i++) begin
        c = get_cfg(i);
        if (s_rd[i] !== exp_rd(c, n) ||
            s_addr[i] !== exp_addr(c, n)) begin
          if (bad == 0)
            msg = $sformatf("inst %0d n=%0d rd=%b addr=%h want %b %h",
                            i, n, s_rd[i], s_addr[i],
                            exp_rd(c, n), exp_addr(c, n));
          bad++;
        end
      end
      if (n > 800 && n <= 1600 && s_rd[0] === 1'b1) cnt1++;
      if (n == 640) begin
        tests++;
        if (s_addr[0] !== 32'h127F || s_rd[0] !== 1'b1) begin
          fails++;
          $display("FAIL line0_end: rd=%b addr=%h, want 1 0000127f",
                   s_rd[0], s_addr[0]);
        end
      end
      if (n == 700) begin
        tests++;
        if (s_addr[0] !== 32'h127F || s_rd[0] !== 1'b0) begin
          fails++;
          $display("FAIL line0_hold: rd=%b addr=%h, want 0 0000127f",
                   s_rd[0], s_addr[0]);
        end
      end
      if (n == 801) begin
        tests++;
        if (s_addr[0] !== 32'h1280 || s_rd[0] !== 1'b1) begin
          fails++;
          $display("FAIL line1_start: rd=%b addr=%h, want 1 00001280",
                   s_rd[0], s_addr[0]);
        end
      end
    end
    tests++;
    if (bad != 0) begin
      fails++;
      $display("FAIL addr_sweep: %0d wrong, first %s", bad, msg);
    end
    tests++;
    if (cnt1 != 640) begin
      fails++;
      $display("FAIL line1_strobes: got %0d want 640", cnt1);
    end
  endtask

  task automatic test_colour();
    cfg_t c;
    int bad = 0;
    int leak = 0;
    int x;
    string msg = "";
    while (n < 2403) begin
      @(negedge clock);
      for (int i = 0; i < 3; i++) begin
        c = get_cfg(i);
        if (act_out(i) !== exp_out(c, n)) begin
          if (bad == 0)
            msg = $sformatf("inst %0d n=%0d got %h want %h",
                            i, n, act_out(i), exp_out(c, n));
          bad++;
        end
      end
      x = n - 1604;
      if (x >= 640 && {s_r[0], s_g[0], s_b[0]} !== 24'h0) leak++;
      if (x >= 0 && x < 5) begin
        tests++;
        if ({s_r[0], s_g[0], s_b[0]} !== pat_rgb(x)) begin
          fails++;
          $display("FAIL colour_pattern x=%0d: got %h want %h",
                   x, {s_r[0], s_g[0], s_b[0]}, pat_rgb(x));
        end
      end
    end
    tests++;
    if (bad != 0) begin
      fails++;
      $display("FAIL colour_model: %0d wrong, first %s", bad, msg);
    end
    tests++;
    if (leak != 0) begin
      fails++;
      $display("FAIL blank_colour: %0d nonzero cycles, want 0", leak);
    end
  endtask

  task automatic test_sync();
    cfg_t c;
    int bad = 0;
    int start = 0;
    int hs_low = 0, bl_hi = 0, vs_low = 0, runs = 0;
    int s_vs_low [3];
    int s_bl_hi  [3];
    int s_fs_cnt [3];
    int s_strobe [3];
    int wraps = 0;
    logic prev_hs = 1'b1;
    logic prev_rd = 1'b0;
    logic [31:0] prev_addr = 32'h0;
    string msg = "";
    for (int i = 0; i < 3; i++) begin
      s_vs_low[i] = 0; s_bl_hi[i] = 0;
      s_fs_cnt[i] = 0; s_strobe[i] = 0;
    end
    start = n;
    while (n < start + 1600) begin
      @(negedge clock);
      for (int i = 0; i < 3; i++) begin
        c = get_cfg(i);
        if (act_out(i) !== exp_out(c, n)) begin
          if (bad == 0)
            msg = $sformatf("inst %0d n=%0d got %h want %h",
                            i, n, act_out(i), exp_out(c, n));
          bad++;
        end
        if (i != 0 && n <= start + 1232) begin
          if (s_vs[i] === 1'b0) s_vs_low[i]++;
          if (s_bl[i] === 1'b1) s_bl_hi[i]++;
          if (s_fs[i] === 1'b1) s_fs_cnt[i]++;
          if (s_rd[i] === 1'b1) s_strobe[i]++;
        end
      end
      if (s_hs[0] === 1'b0) hs_low++;
      if (s_bl[0] === 1'b1) bl_hi++;
      if (s_vs[0] === 1'b0) vs_low++;
      if (prev_hs === 1'b1 && s_hs[0] === 1'b0) begin
        runs++;
        tests++;
        if ((n - 4) % 800 != 656) begin
          fails++;
          $display("FAIL hs_start: column %0d want 656", (n - 4) % 800);
        end
      end
      if (s_rd[1] === 1'b1 && prev_rd === 1'b0 &&
          prev_addr == 32'd239) begin
        wraps++;
        tests++;
        if (s_addr[1] !== 32'h0) begin
          fails++;
          $display("FAIL frame_wrap_addr: got %h want 0", s_addr[1]);
        end
      end
      prev_hs = s_hs[0];
      prev_rd = s_rd[1];
      prev_addr = s_addr[1];
    end
    tests++;
    if (bad != 0) begin
      fails++;
      $display("FAIL sync_model: %0d wrong, first %s", bad, msg);
    end
    tests++;
    if (hs_low != 192 || runs != 2 || bl_hi != 1280 || vs_low != 0) begin
      fails++;
      $display("FAIL main_line_counts: hs_low=%0d runs=%0d bl=%0d vs=%0d, want 192 2 1280 0",
               hs_low, runs, bl_hi, vs_low);
    end
    for (int i = 1; i < 3; i++) begin
      tests++;
      if (s_vs_low[i] != 224 || s_bl_hi[i] != 480 ||
          s_fs_cnt[i] != 2 || s_strobe[i] != 480) begin
        fails++;
        $display("FAIL frame_counts[%0d]: vs=%0d bl=%0d fs=%0d rd=%0d, want 224 480 2 480",
                 i, s_vs_low[i], s_bl_hi[i], s_fs_cnt[i], s_strobe[i]);
      end
    end
    tests++;
    if (wraps == 0) begin
      fails++;
      $display("FAIL frame_wrap_seen: got 0 wraps want >=1");
    end
  endtask

  task automatic test_mid_reset();
    cfg_t c;
    int guard = 0;
    int bad = 0;
    string msg = "";
    while (n % 800 != 300 && guard < 900) begin
      @(negedge clock);
      guard++;
    end
    tests++;
    if (n % 800 != 300) begin
      fails++;
      $display("FAIL mid_reset_align: h=%0d want 300", n % 800);
    end
    reset = 1'b1;
    #1;
    for (int i = 0; i < 3; i++) begin
      c = get_cfg(i);
      tests++;
      if (s_rd[i] !== 1'b0 || s_addr[i] !== c.base ||
          act_out(i) !== IDLE) begin
        fails++;
        $display("FAIL mid_reset_async[%0d]: rd=%b addr=%h out=%h",
                 i, s_rd[i], s_addr[i], act_out(i));
      end
    end
    @(negedge clock);
    #2 reset = 1'b0;
    while (n < 900) begin
      @(negedge clock);
      c = get_cfg(0);
      if (s_rd[0] !== exp_rd(c, n) || s_addr[0] !== exp_addr(c, n) ||
          act_out(0) !== exp_out(c, n)) begin
        if (bad == 0)
          msg = $sformatf("n=%0d rd=%b addr=%h out=%h want %b %h %h",
                          n, s_rd[0], s_addr[0], act_out(0),
                          exp_rd(c, n), exp_addr(c, n), exp_out(c, n));
        bad++;
      end
      if (n == 4) begin
        tests++;
        if (s_fs[0] !== 1'b1) begin
          fails++;
          $display("FAIL restart_fs: got %b want 1", s_fs[0]);
        end
      end
    end
    tests++;
    if (bad != 0) begin
      fails++;
      $display("FAIL restart_model: %0d wrong, first %s", bad, msg);
    end
  endtask

  task automatic test_latency();
    cfg_t c;
    int bad = 0;
    int x;
    string msg = "";
    @(negedge clock);
    reset = 1'b1;
    #2 reset = 1'b0;
    while (n < 1300) begin
      @(negedge clock);
      for (int i = 0; i < 3; i++) begin
        c = get_cfg(i);
        if (act_out(i) !== exp_out(c, n) ||
            s_addr[i] !== exp_addr(c, n)) begin
          if (bad == 0)
            msg = $sformatf("inst %0d n=%0d got %h want %h",
                            i, n, act_out(i), exp_out(c, n));
          bad++;
        end
        x = n - (c.lat + 2);
        if (i != 0 && x >= 0 && x < 40) begin
          tests++;
          if ({s_r[i], s_g[i], s_b[i]} !== expand(8'(x)) ||
              s_bl[i] !== 1'b1 || s_hs[i] !== 1'b1) begin
            fails++;
            $display("FAIL addr_as_data[%0d] x=%0d: rgb=%h bl=%b hs=%b, want %h 1 1",
                     i, x, {s_r[i], s_g[i], s_b[i]}, s_bl[i], s_hs[i],
                     expand(8'(x)));
          end
        end
      end
    end
    tests++;
    if (bad != 0) begin
      fails++;
      $display("FAIL latency_model: %0d wrong, first %s", bad, msg);
    end
  endtask

  initial begin
    tests = 0;
    fails = 0;
    reset = 1'b1;
    for (int i = 0; i < 256; i++) rnd[i] = 8'($urandom);
    test_reset();
    test_address();
    test_colour();
    test_sync();
    test_mid_reset();
    test_latency();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
